// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer: packs 24-bit RGB pixels (one per handshake) into a
// 32-bit AXI4-Stream, four pixels per three words, little-endian lanes.
// tuser marks the first word of a frame; tlast marks the last word of a line.
// A partial group at end of line is flushed as a byte-masked word.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | accepting pixels, packing them into words by phase
// FLUSH | end of line left residue bytes; emit them as a masked word
module rgb_stream_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter bit         SWAP_RB  = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  input  logic        out_stream_tready,
  output logic        out_stream_tvalid,
  output logic        out_stream_tuser,
  output logic        align_err
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [1:0]  phase;
  logic [23:0] residue;
  logic        pending_sof;

  logic [23:0] pix;
  logic        out_free;
  logic        accept;
  logic [1:0]  eff_phase;

  logic        acc_emit;
  logic [31:0] acc_word;
  logic [23:0] acc_residue;
  logic [1:0]  acc_phase;

  logic [31:0] flush_word;
  logic [3:0]  flush_keep;

  assign pix             = SWAP_RB ? {b, g, r} : {r, g, b};
  assign out_free        = !out_stream_tvalid || out_stream_tready;
  assign in_stream_ready = (state == RUN) && out_free;
  assign accept          = valid && in_stream_ready;
  // A start-of-frame pixel always begins a fresh group; stale residue is dropped.
  assign eff_phase       = sof ? 2'd0 : phase;

  // Word assembly for an accepted pixel, chosen by the group phase.
  always_comb begin
    acc_emit    = 1'b0;
    acc_word    = 32'h0;
    acc_residue = 24'h0;
    acc_phase   = 2'd0;
    case (eff_phase)
      2'd0: begin
        acc_residue = pix;
        acc_phase   = 2'd1;
      end
      2'd1: begin
        acc_emit    = 1'b1;
        acc_word    = {pix[7:0], residue[23:0]};
        acc_residue = {8'h00, pix[23:8]};
        acc_phase   = 2'd2;
      end
      2'd2: begin
        acc_emit    = 1'b1;
        acc_word    = {pix[15:0], residue[15:0]};
        acc_residue = {16'h0000, pix[23:16]};
        acc_phase   = 2'd3;
      end
      default: begin
        acc_emit    = 1'b1;
        acc_word    = {pix[23:0], residue[7:0]};
        acc_residue = 24'h0;
        acc_phase   = 2'd0;
      end
    endcase
  end

  // Masked residue word: residue bytes in the low lanes, padding above.
  always_comb begin
    flush_word = {4{PAD_BYTE}};
    flush_keep = 4'b0000;
    case (phase)
      2'd1: begin
        flush_word = {PAD_BYTE, residue[23:0]};
        flush_keep = 4'b0111;
      end
      2'd2: begin
        flush_word = {PAD_BYTE, PAD_BYTE, residue[15:0]};
        flush_keep = 4'b0011;
      end
      2'd3: begin
        flush_word = {PAD_BYTE, PAD_BYTE, PAD_BYTE, residue[7:0]};
        flush_keep = 4'b0001;
      end
      default: begin
        flush_word = {4{PAD_BYTE}};
        flush_keep = 4'b0000;
      end
    endcase
  end

  // Packing FSM plus the single-stage output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= RUN;
      phase             <= 2'd0;
      residue           <= 24'h0;
      pending_sof       <= 1'b0;
      align_err         <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= 32'h0;
      out_stream_tkeep  <= 4'h0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
    end else begin
      // A transferred word retires unless a new one is loaded below.
      if (out_free) begin
        out_stream_tvalid <= 1'b0;
      end
      if (state == FLUSH) begin
        if (out_free) begin
          out_stream_tvalid <= 1'b1;
          out_stream_tdata  <= flush_word;
          out_stream_tkeep  <= flush_keep;
          out_stream_tlast  <= 1'b1;
          out_stream_tuser  <= pending_sof;
          pending_sof       <= 1'b0;
          phase             <= 2'd0;
          residue           <= 24'h0;
          state             <= RUN;
        end
      end else if (accept) begin
        if (sof) begin
          pending_sof <= 1'b1;
          if (phase != 2'd0) begin
            align_err <= 1'b1;
          end
        end
        residue <= acc_residue;
        phase   <= acc_phase;
        if (acc_emit) begin
          out_stream_tvalid <= 1'b1;
          out_stream_tdata  <= acc_word;
          out_stream_tkeep  <= 4'hF;
          out_stream_tlast  <= eol && (acc_phase == 2'd0);
          out_stream_tuser  <= pending_sof;
          pending_sof       <= 1'b0;
        end
        if (eol && (acc_phase != 2'd0)) begin
          state <= FLUSH;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Testbench for rgb_stream_packer: directed table cases, hand-written
// reset/backpressure sequences and random streams against a byte-level model.
module tb_rgb_stream_packer;

  localparam logic [7:0] PAD = 8'h00;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tready;
  logic        out_stream_tvalid;
  logic        out_stream_tuser;
  logic        align_err;

  rgb_stream_packer dut (
    .aclk(aclk), .aresetn(aresetn), .r(r), .g(g), .b(b), .valid(valid),
    .sof(sof), .eol(eol), .in_stream_ready(in_stream_ready),
    .out_stream_tdata(out_stream_tdata), .out_stream_tkeep(out_stream_tkeep),
    .out_stream_tlast(out_stream_tlast), .out_stream_tready(out_stream_tready),
    .out_stream_tvalid(out_stream_tvalid), .out_stream_tuser(out_stream_tuser),
    .align_err(align_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [23:0] p;
    bit          sof;
    bit          eol;
  } pix_t;

  // word record: {tuser, tlast, tkeep, tdata}
  typedef struct packed {
    int               npix;
    logic [0:3][23:0] pix;
    logic [3:0]       sof_m;
    logic [3:0]       eol_m;
    int               nw;
    logic [0:3][37:0] w;
    bit               exp_err;
    bit               exp_rdy;
  } case_t;

  pix_t        tx_q[$];
  logic [37:0] got_q[$];
  logic [37:0] exp_q[$];
  case_t       cases[5];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int mode      = 0;
  int hold_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [37:0] wd(bit u, bit l, logic [3:0] k, logic [31:0] d);
    return {u, l, k, d};
  endfunction

  // Capture every completed output transfer.
  always @(posedge aclk) begin
    if (aresetn && out_stream_tvalid && out_stream_tready)
      got_q.push_back({out_stream_tuser, out_stream_tlast, out_stream_tkeep, out_stream_tdata});
  end

  // Reference: pixels become a little-endian byte stream, cut into 4-byte words.
  task automatic model(output bit err);
    logic [7:0]  bq[$];
    logic [31:0] w;
    logic [3:0]  k;
    bit          pend;
    pend = 0;
    err  = 0;
    exp_q.delete();
    foreach (tx_q[i]) begin
      if (tx_q[i].sof) begin
        if (bq.size() != 0) err = 1;
        bq.delete();
        pend = 1;
      end
      bq.push_back(tx_q[i].p[7:0]);
      bq.push_back(tx_q[i].p[15:8]);
      bq.push_back(tx_q[i].p[23:16]);
      while (bq.size() >= 4) begin
        w = {bq[3], bq[2], bq[1], bq[0]};
        repeat (4) void'(bq.pop_front());
        exp_q.push_back(wd(pend, tx_q[i].eol && bq.size() == 0, 4'hF, w));
        pend = 0;
      end
      if (tx_q[i].eol && bq.size() > 0) begin
        w = {4{PAD}};
        k = 4'b0000;
        for (int j = 0; j < bq.size(); j++) begin
          w[8*j +: 8] = bq[j];
          k[j] = 1'b1;
        end
        exp_q.push_back(wd(pend, 1'b1, k, w));
        pend = 0;
        bq.delete();
      end
    end
  endtask

  task automatic set_tready();
    case (mode)
      0: out_stream_tready = 1'b1;
      1: out_stream_tready = ($urandom_range(0, 3) != 0);
      2: out_stream_tready = 1'b0;
      default: begin
        if (got_q.size() == 1 && out_stream_tvalid && hold_cnt < 5) begin
          out_stream_tready = 1'b0;
          hold_cnt++;
        end else begin
          out_stream_tready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic held_checks();
    if (mode == 3 && !out_stream_tready) begin
      check("hold_tdata", out_stream_tdata, 32'h88994455);
      check("hold_in_ready", in_stream_ready, 1'b0);
    end
  endtask

  task automatic send_stream(input int budget, input bit do_drain, output bit rdy_after);
    int idx = 0;
    int cyc = 0;
    while (idx < tx_q.size() && cyc < budget) begin
      @(negedge aclk);
      set_tready();
      valid = 1'b1;
      {r, g, b} = tx_q[idx].p;
      sof = tx_q[idx].sof;
      eol = tx_q[idx].eol;
      #1;
      held_checks();
      if (in_stream_ready) idx++;
      cyc++;
    end
    check("send_budget", idx, tx_q.size());
    @(negedge aclk);
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    set_tready();
    #1;
    held_checks();
    rdy_after = in_stream_ready;
    if (do_drain) begin
      cyc = 0;
      while (!(!out_stream_tvalid && in_stream_ready) && cyc < 200) begin
        @(negedge aclk);
        set_tready();
        #1;
        held_checks();
        cyc++;
      end
      check("drain_budget", cyc < 200, 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    got_q.delete();
  endtask

  task automatic compare_q(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(name, got_q[i], exp_q[i]);
  endtask

  initial begin
    bit rdy, err;
    int nlast;
    logic [23:0] pv;

    aresetn = 1'b0; valid = 1'b0; sof = 1'b0; eol = 1'b0;
    r = 8'h0; g = 8'h0; b = 8'h0;
    out_stream_tready = 1'b1;

    cases[0] = '{npix: 4, pix: '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC},
                 sof_m: 4'b0001, eol_m: 4'b1000, nw: 3,
                 w: '{wd(1,0,4'hF,32'h66112233), wd(0,0,4'hF,32'h88994455), wd(0,1,4'hF,32'hAABBCC77), 38'h0},
                 exp_err: 0, exp_rdy: 1};
    cases[1] = '{npix: 2, pix: '{24'h112233, 24'h445566, 24'h0, 24'h0},
                 sof_m: 4'b0000, eol_m: 4'b0010, nw: 2,
                 w: '{wd(0,0,4'hF,32'h66112233), wd(0,1,4'h3,32'h00004455), 38'h0, 38'h0},
                 exp_err: 0, exp_rdy: 0};
    cases[2] = '{npix: 1, pix: '{24'hA1B2C3, 24'h0, 24'h0, 24'h0},
                 sof_m: 4'b0001, eol_m: 4'b0001, nw: 1,
                 w: '{wd(1,1,4'h7,32'h00A1B2C3), 38'h0, 38'h0, 38'h0},
                 exp_err: 0, exp_rdy: 0};
    cases[3] = '{npix: 4, pix: '{24'h112233, 24'h445566, 24'h778899, 24'hDDEEFF},
                 sof_m: 4'b0100, eol_m: 4'b1000, nw: 3,
                 w: '{wd(0,0,4'hF,32'h66112233), wd(1,0,4'hF,32'hFF778899), wd(0,1,4'h3,32'h0000DDEE), 38'h0},
                 exp_err: 1, exp_rdy: 0};
    cases[4] = '{npix: 3, pix: '{24'h010203, 24'h040506, 24'h070809, 24'h0},
                 sof_m: 4'b0000, eol_m: 4'b0100, nw: 3,
                 w: '{wd(0,0,4'hF,32'h06010203), wd(0,0,4'hF,32'h08090405), wd(0,1,4'h1,32'h00000007), 38'h0},
                 exp_err: 0, exp_rdy: 0};

    // reset state
    do_reset();
    #1;
    check("rst_tvalid", out_stream_tvalid, 1'b0);
    check("rst_tdata", out_stream_tdata, 32'h0);
    check("rst_tkeep", out_stream_tkeep, 4'h0);
    check("rst_tlast", out_stream_tlast, 1'b0);
    check("rst_tuser", out_stream_tuser, 1'b0);
    check("rst_align_err", align_err, 1'b0);
    check("rst_in_ready", in_stream_ready, 1'b1);

    // directed table
    for (int c = 0; c < 5; c++) begin
      do_reset();
      mode = 0;
      tx_q.delete();
      exp_q.delete();
      for (int i = 0; i < cases[c].npix; i++)
        tx_q.push_back('{p: cases[c].pix[i], sof: cases[c].sof_m[i], eol: cases[c].eol_m[i]});
      for (int i = 0; i < cases[c].nw; i++) exp_q.push_back(cases[c].w[i]);
      send_stream(200, 1'b1, rdy);
      compare_q($sformatf("case%0d_word", c));
      check($sformatf("case%0d_align_err", c), align_err, cases[c].exp_err);
      check($sformatf("case%0d_ready_after", c), rdy, cases[c].exp_rdy);
    end

    // backpressure on the second word
    do_reset();
    mode = 3;
    hold_cnt = 0;
    tx_q.delete();
    tx_q.push_back('{24'h112233, 1'b1, 1'b0});
    tx_q.push_back('{24'h445566, 1'b0, 1'b0});
    tx_q.push_back('{24'h778899, 1'b0, 1'b0});
    tx_q.push_back('{24'hAABBCC, 1'b0, 1'b1});
    model(err);
    send_stream(200, 1'b1, rdy);
    check("hold_cycles", hold_cnt, 5);
    compare_q("hold_word");

    // asynchronous reset mid-transfer
    do_reset();
    mode = 2;
    tx_q.delete();
    tx_q.push_back('{24'h112233, 1'b0, 1'b0});
    tx_q.push_back('{24'h445566, 1'b1, 1'b0});
    tx_q.push_back('{24'h778899, 1'b0, 1'b1});
    send_stream(50, 1'b0, rdy);
    check("pre_rst_tvalid", out_stream_tvalid, 1'b1);
    check("pre_rst_tdata", out_stream_tdata, 32'h99445566);
    check("pre_rst_tuser", out_stream_tuser, 1'b1);
    check("pre_rst_align_err", align_err, 1'b1);
    check("pre_rst_in_ready", rdy, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_rst_tvalid", out_stream_tvalid, 1'b0);
    check("async_rst_tlast", out_stream_tlast, 1'b0);
    check("async_rst_tuser", out_stream_tuser, 1'b0);
    check("async_rst_align_err", align_err, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    mode = 0;
    out_stream_tready = 1'b1;
    #1;
    check("post_rst_in_ready", in_stream_ready, 1'b1);
    got_q.delete();

    // 640-pixel line, random backpressure
    do_reset();
    mode = 1;
    tx_q.delete();
    for (int i = 0; i < 640; i++) begin
      pv = $urandom() & 24'hFFFFFF;
      tx_q.push_back('{pv, (i == 0), (i == 639)});
    end
    model(err);
    send_stream(5000, 1'b1, rdy);
    check("line640_words", got_q.size(), 480);
    nlast = 0;
    foreach (got_q[i]) if (got_q[i][36]) nlast++;
    check("line640_tlast_count", nlast, 1);
    compare_q("line640_word");

    // random frames/lines with misaligned sof
    do_reset();
    mode = 1;
    tx_q.delete();
    for (int i = 0; i < 300; i++) begin
      pv = $urandom() & 24'hFFFFFF;
      tx_q.push_back('{pv, ($urandom_range(0, 19) == 0), (i == 299) || ($urandom_range(0, 9) == 0)});
    end
    model(err);
    send_stream(5000, 1'b1, rdy);
    compare_q("rand_word");
    check("rand_align_err", align_err, err);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
